// File: rtl/m_axi_mem.sv
// rtl/m_axi_mem.sv - AXI4 INCR burst master driven by a single-command request port
//
// Purpose: accepts one command at a time (address, beat count, direction) and
// issues a matching INCR burst on a full AXI4 master interface. Write data is
// streamed in on wr_*, read data is streamed out on rd_*, and every command
// ends with a one-cycle done pulse carrying the worst response seen.
//
// Ports:
//   m_axi_aclk, m_axi_areset           clock, synchronous active-high reset
//   cmd_valid/ready, cmd_write,
//   cmd_addr, cmd_len                  command request (len = beats - 1)
//   wr_data/strb/valid/ready           write beat stream into the master
//   rd_data/last/valid/ready           read beat stream out of the master
//   done, done_resp, done_len_err      completion pulse and its status
//   m_axi_aw*/w*/b*/ar*/r*             AXI4 master channels

module m_axi_mem #(
   parameter int unsigned         ID_WIDTH   = 1,
   parameter int unsigned         DATA_WIDTH = 32,
   parameter int unsigned         ADDR_WIDTH = 32,
   parameter logic [ID_WIDTH-1:0] M_ID       = '0
) (
   input  logic                    m_axi_aclk,
   input  logic                    m_axi_areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [7:0]              cmd_len,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_last,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic                    done,
   output logic [1:0]              done_resp,
   output logic                    done_len_err,
   output logic [ID_WIDTH-1:0]     m_axi_awid,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [ID_WIDTH-1:0]     m_axi_rid,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   localparam int unsigned SZ = $clog2(DATA_WIDTH/8);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_REJECT
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              len_q, len_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [1:0]              acc_q, acc_d;
   logic                    done_q, done_d;
   logic [1:0]              done_resp_q, done_resp_d;
   logic                    len_err_q, len_err_d;

   logic [ADDR_WIDTH-1:0]   cmd_addr_al;
   logic [19:0]             burst_end;
   logic                    crosses_4k;
   logic [1:0]              resp_max;
   logic                    unused_ok;

   assign cmd_addr_al = {cmd_addr[ADDR_WIDTH-1:SZ], {SZ{1'b0}}};
   // End offset within the 4 KB page; equal to 4096 still fits exactly.
   assign burst_end   = 20'(cmd_addr_al[11:0]) + ((20'(cmd_len) + 20'd1) << SZ);
   assign crosses_4k  = burst_end > 20'd4096;
   assign resp_max    = (m_axi_rresp > acc_q) ? m_axi_rresp : acc_q;
   assign unused_ok   = ^{m_axi_bid, m_axi_rid, cmd_addr[SZ-1:0]};

   assign m_axi_awid    = M_ID;
   assign m_axi_arid    = M_ID;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_awlen   = len_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_awsize  = 3'(SZ);
   assign m_axi_arsize  = 3'(SZ);
   assign m_axi_awburst = 2'b01;
   assign m_axi_arburst = 2'b01;
   assign m_axi_wdata   = wr_data;
   assign m_axi_wstrb   = wr_strb;
   assign m_axi_wlast   = (state_q == S_WR_DATA) && (cnt_q == len_q);
   assign rd_data       = m_axi_rdata;
   assign rd_last       = (state_q == S_RD_DATA) && m_axi_rlast;
   assign done          = done_q;
   assign done_resp     = done_resp_q;
   assign done_len_err  = len_err_q;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      done_d        = 1'b0;
      done_resp_d   = done_resp_q;
      len_err_d     = len_err_q;
      cmd_ready     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      wr_ready      = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      rd_valid      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Gated by reset so a command presented during reset is never taken.
            cmd_ready = !m_axi_areset;
            if (cmd_valid && !m_axi_areset) begin
               addr_d = cmd_addr_al;
               len_d  = cmd_len;
               cnt_d  = 8'd0;
               acc_d  = 2'b00;
               if (crosses_4k)     state_d = S_REJECT;
               else if (cmd_write) state_d = S_WR_ADDR;
               else                state_d = S_RD_ADDR;
            end
         end
         S_WR_ADDR: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_d = S_WR_DATA;
         end
         S_WR_DATA: begin
            m_axi_wvalid = wr_valid;
            wr_ready     = m_axi_wready;
            if (wr_valid && m_axi_wready) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == len_q) state_d = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               done_d      = 1'b1;
               done_resp_d = m_axi_bresp;
               len_err_d   = 1'b0;
               state_d     = S_IDLE;
            end
         end
         S_RD_ADDR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) state_d = S_RD_DATA;
         end
         S_RD_DATA: begin
            rd_valid     = m_axi_rvalid;
            m_axi_rready = rd_ready;
            if (m_axi_rvalid && rd_ready) begin
               cnt_d = cnt_q + 8'd1;
               acc_d = resp_max;
               // The slave's rlast ends the burst; a count mismatch is only reported.
               if (m_axi_rlast) begin
                  done_d      = 1'b1;
                  done_resp_d = resp_max;
                  len_err_d   = (cnt_q != len_q);
                  state_d     = S_IDLE;
               end
            end
         end
         S_REJECT: begin
            done_d      = 1'b1;
            done_resp_d = 2'b10;
            len_err_d   = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         done_q      <= 1'b0;
         done_resp_q <= 2'b00;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         done_q      <= done_d;
         done_resp_q <= done_resp_d;
         len_err_q   <= len_err_d;
      end
   end

endmodule

// File: tb/tb_m_axi_mem.sv
// tb/tb_m_axi_mem.sv - directed self-checking bench for m_axi_mem

module tb_m_axi_mem;

   logic        clk = 1'b0;
   logic        m_axi_areset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_last, rd_valid, rd_ready;
   logic        done, done_len_err;
   logic [1:0]  done_resp;
   logic [0:0]  awid, bid, arid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [3:0]  wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   m_axi_mem #(.ID_WIDTH(1), .DATA_WIDTH(32), .ADDR_WIDTH(32), .M_ID(1'b0)) dut (
      .m_axi_aclk(clk), .m_axi_areset(m_axi_areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .done_resp(done_resp), .done_len_err(done_len_err),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
      .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
      .m_axi_wready(wready),
      .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
      .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   task automatic test_reset();
      m_axi_areset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready_in_reset got %b exp 0", cmd_ready); end
      @(negedge clk);
      m_axi_areset = 1'b0; cmd_valid = 1'b0;
      #1;
      checks++;
      if ({awvalid, arvalid, wvalid, wlast, bready, rready, wr_ready, rd_valid, done, done_len_err, done_resp} !== 12'h000) begin
         errors++;
         $display("FAIL rst_outputs got %h exp 000",
                  {awvalid, arvalid, wvalid, wlast, bready, rready, wr_ready, rd_valid, done, done_len_err, done_resp});
      end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready_after got %b exp 1", cmd_ready); end
   endtask

   task automatic test_write();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_len = 8'd3;
      awready = 1'b1; wready = 1'b1; wr_valid = 1'b1; wr_data = 32'hA000_0000; wr_strb = 4'hF; bvalid = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      checks++;
      if ({awvalid, awaddr, awlen, awsize, awburst, awid} !== {1'b1, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0}) begin
         errors++;
         $display("FAIL wr_aw got %h exp %h", {awvalid, awaddr, awlen, awsize, awburst, awid},
                  {1'b1, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0});
      end
      checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL wr_no_early_w got %b exp 0", wvalid); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wr_data = 32'(32'hA000_0000 + i);
         #1;
         checks++;
         if ({wvalid, wr_ready, wlast, wstrb, wdata} !== {1'b1, 1'b1, (i == 3), 4'hF, 32'(32'hA000_0000 + i)}) begin
            errors++;
            $display("FAIL wr_beat%0d got %h exp %h", i, {wvalid, wr_ready, wlast, wstrb, wdata},
                     {1'b1, 1'b1, (i == 3), 4'hF, 32'(32'hA000_0000 + i)});
         end
      end
      @(negedge clk);
      wr_valid = 1'b0; bvalid = 1'b1; bresp = 2'b00;
      #1;
      checks++; if ({bready, done} !== 2'b10) begin errors++; $display("FAIL wr_b_phase got %b exp 10", {bready, done}); end
      @(negedge clk);
      bvalid = 1'b0;
      #1;
      checks++;
      if ({done, done_resp, done_len_err, cmd_ready} !== 5'b1_00_0_1) begin
         errors++; $display("FAIL wr_done got %b exp 10001", {done, done_resp, done_len_err, cmd_ready});
      end
      @(negedge clk);
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got %b exp 0", done); end
   endtask

   task automatic test_read_single();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_len = 8'd0;
      arready = 1'b1; rd_ready = 1'b1; rvalid = 1'b0; rlast = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      checks++;
      if ({arvalid, araddr, arlen, arsize, arburst, arid, awvalid} !== {1'b1, 32'h40, 8'd0, 3'd2, 2'b01, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rd1_ar got %h exp %h", {arvalid, araddr, arlen, arsize, arburst, arid, awvalid},
                  {1'b1, 32'h40, 8'd0, 3'd2, 2'b01, 1'b0, 1'b0});
      end
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10; rlast = 1'b1;
      #1;
      checks++;
      if ({rd_valid, rready, rd_last, rd_data} !== {1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL rd1_beat got %h exp %h", {rd_valid, rready, rd_last, rd_data}, {3'b111, 32'hDEAD_BEEF});
      end
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0;
      #1;
      checks++;
      if ({done, done_resp, done_len_err} !== 4'b1_10_0) begin
         errors++; $display("FAIL rd1_done got %b exp 1100", {done, done_resp, done_len_err});
      end
   endtask

   task automatic test_read_short();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; cmd_len = 8'd3;
      arready = 1'b1; rd_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'h1; rresp = 2'b00; rlast = 1'b0;
      #1;
      checks++; if ({rd_last, done} !== 2'b00) begin errors++; $display("FAIL rds_beat0 got %b exp 00", {rd_last, done}); end
      @(negedge clk);
      rdata = 32'h2; rresp = 2'b01; rlast = 1'b1;
      #1;
      checks++; if ({rd_valid, rd_last} !== 2'b11) begin errors++; $display("FAIL rds_beat1 got %b exp 11", {rd_valid, rd_last}); end
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0;
      #1;
      checks++;
      if ({done, done_resp, done_len_err} !== 4'b1_01_1) begin
         errors++; $display("FAIL rds_done got %b exp 1011", {done, done_resp, done_len_err});
      end
   endtask

   task automatic test_reject();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFF8; cmd_len = 8'd3;
      wr_valid = 1'b1; awready = 1'b1; wready = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rej_cmd_ready got %b exp 1", cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      checks++;
      if ({awvalid, wvalid, wr_ready, done, cmd_ready} !== 5'b00000) begin
         errors++; $display("FAIL rej_mid got %b exp 00000", {awvalid, wvalid, wr_ready, done, cmd_ready});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({done, done_resp, cmd_ready, awvalid} !== 5'b1_10_1_0) begin
         errors++; $display("FAIL rej_done got %b exp 11010", {done, done_resp, cmd_ready, awvalid});
      end
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      checks++;
      if ({done, done_resp} !== 3'b0_10) begin
         errors++; $display("FAIL rej_resp_hold got %b exp 010", {done, done_resp});
      end
   endtask

   task automatic test_write_stalls();
      logic [15:0] vpat = 16'hFFED;
      logic [15:0] rpat = 16'hFFF6;
      int i = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFF3; cmd_len = 8'd3;
      awready = 1'b0; wready = 1'b0; wr_valid = 1'b0; wr_strb = 4'h5;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      checks++;
      if ({awvalid, awaddr} !== {1'b1, 32'hFF0}) begin errors++; $display("FAIL st_aw got %h exp 1_00000ff0", {awvalid, awaddr}); end
      @(negedge clk);
      #1;
      checks++;
      if ({awvalid, awaddr, awlen} !== {1'b1, 32'hFF0, 8'd3}) begin
         errors++; $display("FAIL st_aw_hold got %h exp %h", {awvalid, awaddr, awlen}, {1'b1, 32'hFF0, 8'd3});
      end
      @(negedge clk);
      awready = 1'b1;
      #1;
      checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL st_aw_hold2 got %b exp 1", awvalid); end
      for (int c = 0; c < 16 && i < 4; c++) begin
         @(negedge clk);
         awready = 1'b0; wr_valid = vpat[c]; wready = rpat[c]; wr_data = 32'(32'hB0 + i);
         #1;
         checks++;
         if ({wvalid, wr_ready, wlast, wstrb, wdata} !== {vpat[c], rpat[c], (i == 3), 4'h5, 32'(32'hB0 + i)}) begin
            errors++;
            $display("FAIL st_w_c%0d got %h exp %h", c, {wvalid, wr_ready, wlast, wstrb, wdata},
                     {vpat[c], rpat[c], (i == 3), 4'h5, 32'(32'hB0 + i)});
         end
         if (vpat[c] && rpat[c]) i++;
      end
      checks++; if (i != 4) begin errors++; $display("FAIL st_beats got %0d exp 4", i); end
      @(negedge clk);
      wr_valid = 1'b0; bvalid = 1'b0;
      #1;
      checks++; if ({bready, done} !== 2'b10) begin errors++; $display("FAIL st_b_wait got %b exp 10", {bready, done}); end
      @(negedge clk);
      bvalid = 1'b1; bresp = 2'b01;
      @(negedge clk);
      bvalid = 1'b0;
      #1;
      checks++;
      if ({done, done_resp, done_len_err} !== 4'b1_01_0) begin
         errors++; $display("FAIL st_done got %b exp 1010", {done, done_resp, done_len_err});
      end
   endtask

   task automatic test_read_stalls();
      logic [11:0] rp = 12'b1111_1101_1010;
      logic [5:0]  rtab = {2'b01, 2'b10, 2'b00};
      int i = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h300; cmd_len = 8'd2;
      arready = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      checks++;
      if ({arvalid, araddr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL rs_ar got %h exp 1_00000300", {arvalid, araddr}); end
      @(negedge clk);
      arready = 1'b1;
      #1;
      checks++;
      if ({arvalid, araddr, arlen} !== {1'b1, 32'h300, 8'd2}) begin
         errors++; $display("FAIL rs_ar_hold got %h exp %h", {arvalid, araddr, arlen}, {1'b1, 32'h300, 8'd2});
      end
      for (int c = 0; c < 12 && i < 3; c++) begin
         @(negedge clk);
         arready = 1'b0; rvalid = 1'b1; rd_ready = rp[c]; rdata = 32'(32'hC0 + i);
         rresp = rtab[2*i +: 2]; rlast = (i == 2);
         #1;
         checks++;
         if ({rd_valid, rready, rd_last, rd_data} !== {1'b1, rp[c], (i == 2), 32'(32'hC0 + i)}) begin
            errors++;
            $display("FAIL rs_r_c%0d got %h exp %h", c, {rd_valid, rready, rd_last, rd_data},
                     {1'b1, rp[c], (i == 2), 32'(32'hC0 + i)});
         end
         if (rp[c]) i++;
      end
      checks++; if (i != 3) begin errors++; $display("FAIL rs_beats got %0d exp 3", i); end
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b1;
      #1;
      checks++;
      if ({done, done_resp, done_len_err} !== 4'b1_10_0) begin
         errors++; $display("FAIL rs_done got %b exp 1100", {done, done_resp, done_len_err});
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_len = 8'd3;
      awready = 1'b1; wready = 1'b1; wr_valid = 1'b1; wr_data = 32'h55;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      m_axi_areset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({awvalid, wvalid, wr_ready, bready, arvalid, rready, rd_valid, done, cmd_ready} !== 9'h000) begin
         errors++;
         $display("FAIL rm_outputs got %b exp 000000000",
                  {awvalid, wvalid, wr_ready, bready, arvalid, rready, rd_valid, done, cmd_ready});
      end
      m_axi_areset = 1'b0; wr_valid = 1'b0;
      #1;
      checks++; if ({done, cmd_ready} !== 2'b01) begin errors++; $display("FAIL rm_idle got %b exp 01", {done, cmd_ready}); end
      @(negedge clk);
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_no_done got %b exp 0", done); end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h600; cmd_len = 8'd0;
      arready = 1'b1; rd_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'h66; rresp = 2'b00; rlast = 1'b1;
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0;
      #1;
      checks++;
      if ({done, done_resp, done_len_err} !== 4'b1_00_0) begin
         errors++; $display("FAIL rm_recover got %b exp 1000", {done, done_resp, done_len_err});
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_len = 8'd0;
      arready = 1'b1; rd_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'h88; rresp = 2'b00; rlast = 1'b1;
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFFC; cmd_len = 8'd1;
      #1;
      checks++;
      if ({done, done_resp, cmd_ready} !== 4'b1_00_1) begin
         errors++; $display("FAIL b2b_overlap got %b exp 1001", {done, done_resp, cmd_ready});
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      checks++; if ({done, cmd_ready} !== 2'b00) begin errors++; $display("FAIL b2b_reject_mid got %b exp 00", {done, cmd_ready}); end
      @(negedge clk);
      #1;
      checks++;
      if ({done, done_resp, awvalid} !== 4'b1_10_0) begin
         errors++; $display("FAIL b2b_reject_done got %b exp 1100", {done, done_resp, awvalid});
      end
   endtask

   initial begin
      m_axi_areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
      arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      test_reset();
      test_write();
      test_read_single();
      test_read_short();
      test_reject();
      test_write_stalls();
      test_read_stalls();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
